// File: rtl/wb_periph_pkg.sv
// Shared types and constants for the Wishbone peripheral controller.
// Used by wb_periph_decode and wb_periph_ctrl.
package wb_periph_pkg;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [31:0] ERR_DECODE  = 32'hBADA_DD00;
  localparam logic [31:0] ERR_TIMEOUT = 32'hDEAD_0000;
  localparam int          CNT_W       = 10;

  // A slot index always needs at least one bit, even for a single slot.
  function automatic int slot_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_periph_decode.sv
// Combinational address decoder: maps a host byte address to a slot
// and flags whether it falls inside the populated peripheral window.
module wb_periph_decode
  import wb_periph_pkg::*;
#(
  parameter int          NUM_SLAVES = 4,
  parameter int          SLOT_AW    = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  localparam int         SW         = slot_width(NUM_SLAVES)
) (
  input  logic [31:0]   adr,
  output logic          hit,
  output logic [SW-1:0] slot
);

  localparam logic [SW:0] NS = (SW+1)'(NUM_SLAVES);

  always_comb begin
    slot = adr[SLOT_AW +: SW];
    // Upper bits must match the base, and the slot must be populated.
    hit  = (adr[31:SLOT_AW+SW] == BASE_ADDR[31:SLOT_AW+SW]) && ({1'b0, slot} < NS);
  end

endmodule

// File: rtl/wb_periph_ctrl.sv
// Wishbone transaction controller fanning one host port out to NUM_SLAVES
// peripherals, with wait-state timeout. Optional macro: WB_PERIPH_ERR_IRQ_EN.
module wb_periph_ctrl
  import wb_periph_pkg::*;
#(
  parameter int          NUM_SLAVES = 4,
  parameter int          SLOT_AW    = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          TIMEOUT    = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  output logic [NUM_SLAVES-1:0]    s_cyc_o,
  output logic [NUM_SLAVES-1:0]    s_stb_o,
  output logic                     s_we_o,
  output logic [3:0]               s_sel_o,
  output logic [SLOT_AW-1:0]       s_adr_o,
  output logic [31:0]              s_dat_o,
  input  logic [32*NUM_SLAVES-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]    s_ack_i
`ifdef WB_PERIPH_ERR_IRQ_EN
  ,
  output logic                     err_irq_o
`endif
);

  localparam int             SW       = slot_width(NUM_SLAVES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [SW-1:0]          slot_q;
  logic                   dec_hit;
  logic [SW-1:0]          dec_slot;
  logic [NUM_SLAVES-1:0]  onehot;
  logic [NUM_SLAVES-1:0]  slot_ack;
  logic [31:0]            slot_dat [NUM_SLAVES];
  logic [31:0]            rd_dat;
  logic                   ack_hit;
  logic                   host_req;

  wb_periph_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLOT_AW    (SLOT_AW),
    .BASE_ADDR  (BASE_ADDR)
  ) u_decode (
    .adr  (wbs_adr_i),
    .hit  (dec_hit),
    .slot (dec_slot)
  );

  // Acks from any slot other than the latched one are masked out here.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slot
      assign onehot[gi]   = (dec_slot == SW'(gi));
      assign slot_ack[gi] = s_ack_i[gi] && (slot_q == SW'(gi));
      assign slot_dat[gi] = s_dat_i[32*gi +: 32];
    end
  endgenerate

  always_comb begin
    rd_dat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (slot_q == SW'(i)) rd_dat = slot_dat[i];
    end
  end

  assign ack_hit  = |slot_ack;
  assign host_req = wbs_cyc_i && wbs_stb_i && !wbs_ack_o;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      slot_q    <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      s_cyc_o   <= '0;
      s_stb_o   <= '0;
      s_we_o    <= 1'b0;
      s_sel_o   <= '0;
      s_adr_o   <= '0;
      s_dat_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          wbs_ack_o <= 1'b0;
          wbs_dat_o <= '0;
          if (host_req) begin
            s_we_o  <= wbs_we_i;
            s_sel_o <= wbs_sel_i;
            s_adr_o <= wbs_adr_i[SLOT_AW-1:0];
            s_dat_o <= wbs_dat_i;
            slot_q  <= dec_slot;
            cnt     <= '0;
            if (dec_hit) begin
              s_cyc_o <= onehot;
              s_stb_o <= onehot;
              state   <= REQ;
            end else begin
              wbs_dat_o <= ERR_DECODE;
              wbs_ack_o <= 1'b1;
              state     <= RESP;
            end
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          // Host abort takes priority over a same-cycle slave ack.
          if (!wbs_cyc_i) begin
            s_cyc_o <= '0;
            s_stb_o <= '0;
            state   <= IDLE;
          end else if (ack_hit) begin
            s_cyc_o   <= '0;
            s_stb_o   <= '0;
            wbs_dat_o <= s_we_o ? 32'h0 : rd_dat;
            wbs_ack_o <= 1'b1;
            state     <= RESP;
          end else if (cnt == CNT_LAST) begin
            s_cyc_o   <= '0;
            s_stb_o   <= '0;
            wbs_dat_o <= ERR_TIMEOUT | 32'(slot_q);
            wbs_ack_o <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          wbs_ack_o <= 1'b0;
          wbs_dat_o <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_PERIPH_ERR_IRQ_EN
  // Tracks the two error exits of the FSM so the pulse lands in RESP.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      err_irq_o <= 1'b0;
    end else begin
      err_irq_o <= ((state == IDLE) && host_req && !dec_hit) ||
                   ((state == REQ) && wbs_cyc_i && !ack_hit && (cnt == CNT_LAST));
    end
  end
`endif

endmodule

// File: tb/tb_wb_periph_ctrl.sv
// Directed scoreboard bench for wb_periph_ctrl (NUM_SLAVES=3, TIMEOUT=8).
module tb_wb_periph_ctrl;

  localparam int NS = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cyc, stb, we;
  logic [3:0]        sel;
  logic [31:0]       adr, dat;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic [NS-1:0]     s_cyc_o, s_stb_o;
  logic              s_we_o;
  logic [3:0]        s_sel_o;
  logic [15:0]       s_adr_o;
  logic [31:0]       s_dat_o;
  logic [32*NS-1:0]  s_dat_i;
  logic [NS-1:0]     s_ack_i;
`ifdef WB_PERIPH_ERR_IRQ_EN
  logic              err_irq_o;
`endif

  always #5 clk = ~clk;

  wb_periph_ctrl #(
    .NUM_SLAVES (NS),
    .SLOT_AW    (16),
    .BASE_ADDR  (32'h3000_0000),
    .TIMEOUT    (8)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_we_o    (s_we_o),
    .s_sel_o   (s_sel_o),
    .s_adr_o   (s_adr_o),
    .s_dat_o   (s_dat_o),
    .s_dat_i   (s_dat_i),
    .s_ack_i   (s_ack_i)
`ifdef WB_PERIPH_ERR_IRQ_EN
    ,
    .err_irq_o (err_irq_o)
`endif
  );

  typedef struct packed {
    logic [31:0] dat;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
  endtask

  task automatic stop();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic expect_ack(input logic [31:0] d, input logic irq);
    exp_t e;
    e.dat = d;
    e.irq = irq;
    exp_q.push_back(e);
  endtask

  // Monitor: every host ack pops one expectation; between acks data must be 0.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (wbs_ack_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack with %h required no ack", wbs_dat_o);
        end else begin
          e = exp_q.pop_front();
          check("ack_data", wbs_dat_o, e.dat);
`ifdef WB_PERIPH_ERR_IRQ_EN
          check("err_irq", 32'(err_irq_o), 32'(e.irq));
`endif
          $display("txn ack: data=%h expected=%h", wbs_dat_o, e.dat);
        end
      end else begin
        check("dat_zero_no_ack", wbs_dat_o, 32'h0);
`ifdef WB_PERIPH_ERR_IRQ_EN
        check("irq_zero_no_ack", 32'(err_irq_o), 32'h0);
`endif
      end
    end
  end

  task automatic timeout_run(input logic [31:0] a, input logic [NS-1:0] oh, input logic [31:0] ed);
    start(a, 1'b0, 32'h0, 4'hF);
    expect_ack(ed, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("timeout_stb_held", 32'(s_stb_o), 32'(oh));
      check("timeout_no_ack", 32'(wbs_ack_o), 32'h0);
    end
    tick();
    check("timeout_stb_drop", 32'(s_stb_o), 32'h0);
    check("timeout_ack", 32'(wbs_ack_o), 32'h1);
    stop();
    tick();
    check("timeout_single_ack", 32'(wbs_ack_o), 32'h0);
  endtask

  initial begin
    cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat = 0;
    s_dat_i = '0; s_ack_i = '0;
    repeat (3) tick();
    check("rst_stb", 32'(s_stb_o), 32'h0);
    check("rst_cyc", 32'(s_cyc_o), 32'h0);
    check("rst_ack", 32'(wbs_ack_o), 32'h0);
    check("rst_shared", {s_adr_o, 11'h0, s_we_o, s_sel_o}, 32'h0);
    rst = 1'b0;
    tick();

    // Read slot 1, slave acks in first REQ cycle.
    start(32'h3001_0004, 1'b0, 32'h0, 4'hF);
    expect_ack(32'h1234_5678, 1'b0);
    tick();
    check("rd_stb", 32'(s_stb_o), 32'h2);
    check("rd_cyc", 32'(s_cyc_o), 32'h2);
    check("rd_adr", 32'(s_adr_o), 32'h0004);
    check("rd_no_ack_yet", 32'(wbs_ack_o), 32'h0);
    s_ack_i = 3'b010;
    s_dat_i[32 +: 32] = 32'h1234_5678;
    tick();
    check("rd_ack_latency", 32'(wbs_ack_o), 32'h1);
    check("rd_stb_drop", 32'(s_stb_o), 32'h0);
    s_ack_i = '0;
    stop();
    tick();
    check("rd_single_ack", 32'(wbs_ack_o), 32'h0);

    // Write slot 2, three wait states; a stray ack from slot 0 is ignored.
    start(32'h3002_0010, 1'b1, 32'hA5A5_A5A5, 4'hF);
    expect_ack(32'h0, 1'b0);
    s_dat_i[64 +: 32] = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("wr_stb", 32'(s_stb_o), 32'h4);
      check("wr_we", 32'(s_we_o), 32'h1);
      check("wr_dat", s_dat_o, 32'hA5A5_A5A5);
      check("wr_no_ack_yet", 32'(wbs_ack_o), 32'h0);
      s_ack_i = (i == 1) ? 3'b001 : (i == 3) ? 3'b100 : 3'b000;
    end
    tick();
    check("wr_ack", 32'(wbs_ack_o), 32'h1);
    s_ack_i = '0;
    stop();
    tick();
    check("wr_single_ack", 32'(wbs_ack_o), 32'h0);

    // Decode miss outside the window; request held through RESP is not re-accepted there.
    start(32'h4000_0000, 1'b0, 32'h0, 4'hF);
    expect_ack(32'hBADA_DD00, 1'b1);
    tick();
    check("miss_no_stb", 32'(s_stb_o), 32'h0);
    check("miss_ack_latency", 32'(wbs_ack_o), 32'h1);
    tick();
    check("resp_no_accept", 32'(wbs_ack_o), 32'h0);
    expect_ack(32'hBADA_DD00, 1'b1);
    tick();
    check("miss_reaccept", 32'(wbs_ack_o), 32'h1);
    stop();
    tick();

    // Unpopulated slot 3 is a miss.
    start(32'h3003_0000, 1'b0, 32'h0, 4'hF);
    expect_ack(32'hBADA_DD00, 1'b1);
    tick();
    check("slot3_no_stb", 32'(s_stb_o), 32'h0);
    check("slot3_ack", 32'(wbs_ack_o), 32'h1);
    stop();
    tick();

    timeout_run(32'h3000_0000, 3'b001, 32'hDEAD_0000);
    timeout_run(32'h3002_0000, 3'b100, 32'hDEAD_0002);

    // Host abort in second REQ cycle, coinciding with a slave ack.
    start(32'h3001_0008, 1'b0, 32'h0, 4'hF);
    tick();
    check("abort_stb_req1", 32'(s_stb_o), 32'h2);
    tick();
    stop();
    s_ack_i = 3'b010;
    s_dat_i[32 +: 32] = 32'h1111_1111;
    tick();
    check("abort_stb_clear", 32'(s_stb_o), 32'h0);
    check("abort_no_ack", 32'(wbs_ack_o), 32'h0);
    tick();
    s_ack_i = '0;
    check("abort_still_no_ack", 32'(wbs_ack_o), 32'h0);

    start(32'h3000_0020, 1'b0, 32'h0, 4'h3);
    expect_ack(32'hCAFE_F00D, 1'b0);
    tick();
    check("post_abort_stb", 32'(s_stb_o), 32'h1);
    check("post_abort_adr", 32'(s_adr_o), 32'h0020);
    check("post_abort_sel", 32'(s_sel_o), 32'h3);
    s_ack_i = 3'b001;
    s_dat_i[0 +: 32] = 32'hCAFE_F00D;
    tick();
    check("post_abort_ack", 32'(wbs_ack_o), 32'h1);
    s_ack_i = '0;
    stop();
    tick();

    // Asynchronous reset during REQ.
    start(32'h3000_0000, 1'b0, 32'h0, 4'hF);
    tick();
    check("rst_req_stb", 32'(s_stb_o), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_stb", 32'(s_stb_o), 32'h0);
    check("async_rst_cyc", 32'(s_cyc_o), 32'h0);
    check("async_rst_ack", 32'(wbs_ack_o), 32'h0);
    stop();
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("after_rst_ack", 32'(wbs_ack_o), 32'h0);
    check("after_rst_stb", 32'(s_stb_o), 32'h0);

    repeat (2) tick();
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_periph_ctrl.md
Name: wb_periph_ctrl

Overview:
Wishbone transaction controller between the management-SoC Wishbone slave port and NUM_SLAVES user peripherals (UART, SPI, ...). Decodes the host address into a slot, sequences exactly one outstanding transaction to the selected peripheral, and applies a wait-state timeout. Always returns an ack to the host, with fixed error data on a decode miss or timeout, so the host bus cannot hang.

Parameters:
NUM_SLAVES, 4, number of peripheral slots (1..8).
SLOT_AW, 16, byte-address bits per slot; the slot-local offset width.
BASE_ADDR, 32'h3000_0000, base of slot 0; slots are contiguous at 2**SLOT_AW strides.
TIMEOUT, 255, maximum REQ-state cycles before abort (1..1023).

Ports:
wb_clk_i  in  1  single clock
wb_rst_i  in  1  asynchronous, active-high reset
wbs_cyc_i  in  1  host cycle
wbs_stb_i  in  1  host strobe
wbs_we_i  in  1  host write enable
wbs_sel_i  in  4  host byte selects
wbs_adr_i  in  32  host byte address
wbs_dat_i  in  32  host write data
wbs_ack_o  out  1  host ack, one-cycle pulse
wbs_dat_o  out  32  host read data
s_cyc_o  out  NUM_SLAVES  per-slot cycle, one-hot
s_stb_o  out  NUM_SLAVES  per-slot strobe, one-hot
s_we_o  out  1  shared write enable
s_sel_o  out  4  shared byte selects
s_adr_o  out  SLOT_AW  shared slot-local offset
s_dat_o  out  32  shared write data
s_dat_i  in  32*NUM_SLAVES  per-slot read data; slot k occupies bits [32k+31:32k]
s_ack_i  in  NUM_SLAVES  per-slot ack

Behaviour:
- SW = max(1, clog2(NUM_SLAVES)).
- Slot index = adr[SLOT_AW+SW-1:SLOT_AW].
- Hit: adr[31:SLOT_AW+SW] == BASE_ADDR[31:SLOT_AW+SW] and slot index < NUM_SLAVES.
- Reset: state=IDLE; all outputs 0; counter 0; latched slot 0.
- IDLE:
  - On cyc&stb with wbs_ack_o low:
    - Latch we, sel, adr[SLOT_AW-1:0] and dat.
    - Hit: assert s_cyc_o/s_stb_o bit for the slot, go REQ.
    - Miss: load data 32'hBADA_DD00, go RESP; no slot strobe.
- REQ:
  - Strobes held and shared outputs stable; counter increments each cycle.
  - s_ack_i[slot]: latch the slot's s_dat_i slice (0 on write), deassert strobes at the same edge, go RESP.
  - counter == TIMEOUT-1 without ack: deassert strobes, load 32'hDEAD_0000 | slot, go RESP.
  - wbs_cyc_i low: abort, deassert strobes, go IDLE, no host ack.
  - Ack and abort in the same cycle: abort wins.
- RESP: wbs_ack_o=1 for exactly one cycle with wbs_dat_o = latched data; next IDLE.
- wbs_dat_o is 0 whenever wbs_ack_o is 0.
- Latency: slave acking in its first REQ cycle gives host ack 2 cycles after the stb sample. A decode miss acks 1 cycle after the sample.
- s_ack_i from unselected slots and any s_ack_i outside REQ are ignored.
- A new host request sampled in RESP is not accepted; it is accepted only in IDLE.
- Counter is cleared on entry to REQ.
- Async reset mid-transaction: strobes and ack drop immediately; no ack is issued for the in-flight transaction.

Optional Feature:
WB_PERIPH_ERR_IRQ_EN
- Defined: extra output err_irq_o (1 bit). Pulses high in the RESP cycle of a decode miss or timeout. Reset value 0.
- Undefined: port absent; no extra logic.

Decomposition:
- Package wb_periph_pkg: state enum {IDLE, REQ, RESP}, ERR_DECODE=32'hBADA_DD00, ERR_TIMEOUT=32'hDEAD_0000, slot-width function.
- One combinational sub-module, wb_periph_decode: address in, hit and slot out.
- FSM, counter and muxing stay in the top.

Test Plan:
- Read 0x3001_0004; slave 1 acks in first REQ cycle with 0x1234_5678 -> s_stb_o=4'b0010 for one cycle, s_adr_o=16'h0004, wbs_ack_o pulses 2 cycles after the stb sample with 0x1234_5678.
- Write 0x3002_0010, data 0xA5A5_A5A5, sel 4'hF; slave 2 acks after 3 wait cycles -> s_we_o=1, s_dat_o=0xA5A5_A5A5 stable for 4 cycles; single ack; wbs_dat_o=0.
- Read 0x4000_0000 -> no s_stb_o; ack 1 cycle after the sample with 0xBADA_DD00; with WB_PERIPH_ERR_IRQ_EN, err_irq_o pulses in the same cycle.
- NUM_SLAVES=3, read 0x3003_0000 -> decode miss, 0xBADA_DD00.
- TIMEOUT=8, slave 0 never acks -> s_stb_o drops after 8 REQ cycles; ack with 0xDEAD_0000.
- Drop wbs_cyc_i in the 2nd REQ cycle -> strobes clear, no ack, next request served normally.
- Assert wb_rst_i in a separate REQ -> outputs 0 immediately.
